vmon_h2m_decoder: RTL and testbench

VMON_H2M_DECODER -- requirements
Module: vmon_h2m_decoder

---
 rtl/vmon_h2m_pkg.sv | 25 ++
 rtl/vmon_h2m_decoder.sv | 168 ++++++++++++++++
 tb/tb_vmon_h2m_decoder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vmon_h2m_pkg.sv
// vmon_h2m_pkg
//   Shared definitions for the host-to-monitor frame decoder:
//   FSM state encoding, default start-of-frame byte, error codes and
//   the largest payload the decoder can ever be built for.
package vmon_h2m_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_OUT  = 3'd5
    } vmon_h2m_state_e;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;

    // cmd_data is 64 bits wide, so no build may carry more than 8 bytes.
    localparam int unsigned MAX_LEN_LIMIT = 8;

endpackage

// File: rtl/vmon_h2m_decoder.sv
// vmon_h2m_decoder
//   Decodes host-to-monitor frames of the form
//     SOF, OP, LEN, LEN payload bytes, CHK   (CHK = XOR of OP, LEN, payload)
//   and presents each accepted frame as one command.
//
// Handshakes: both streams use strict valid/ready. A byte/command moves on a
//   rising clk edge where valid && ready. A producer keeps valid and payload
//   stable until the transfer; ready never depends combinationally on valid.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   h2m_data/valid/ready input byte stream (ready low only while a command waits)
//   cmd_valid/ready      output command handshake
//   cmd_op/len/data      decoded opcode, payload count, payload (byte i at [8i+7:8i])
//   err_pulse, err_code  one-cycle rejection pulse; code of the latest rejection
//   frame_cnt, err_cnt   accepted frames (wrapping), rejected frames (saturating)
//   dbg_state            current FSM state, for checkers
module vmon_h2m_decoder
    import vmon_h2m_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,          // 1..MAX_LEN_LIMIT
    parameter logic [7:0]  SOF     = SOF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  h2m_data,
    input  logic        h2m_valid,
    output logic        h2m_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_data,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    vmon_h2m_state_e state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [3:0]  len_q, len_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  xor_q, xor_d;
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        accept;

    // Ready comes straight from the state register, so cmd_ready can never
    // reach h2m_ready through logic.
    assign h2m_ready = (state_q != ST_OUT);
    assign accept    = h2m_valid && h2m_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && h2m_data == SOF) begin
                    // Clear the payload now so short frames read zero above LEN.
                    data_d  = '0;
                    state_d = ST_OP;
                end
            end
            ST_OP: begin
                if (accept) begin
                    op_d    = h2m_data;
                    xor_d   = h2m_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (h2m_data > MAX_LEN_B) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = h2m_data[3:0];
                        xor_d   = xor_q ^ h2m_data;
                        cnt_d   = 4'd0;
                        state_d = (h2m_data == 8'd0) ? ST_CHK : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_d[{cnt_q[2:0], 3'b000} +: 8] = h2m_data;
                    xor_d = xor_q ^ h2m_data;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q - 4'd1) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (h2m_data == xor_q) begin
                        state_d = ST_OUT;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_OUT: begin
                if (cmd_ready) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            len_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            xor_q       <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_valid = (state_q == ST_OUT);
    assign cmd_op    = op_q;
    assign cmd_len   = len_q;
    assign cmd_data  = data_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vmon_h2m_decoder.sv
// tb_vmon_h2m_decoder
//   Drives whole frames into vmon_h2m_decoder and compares every outcome with
//   what the frame contents imply: accepted commands go through exp_q,
//   rejection codes and counters are tracked as plain integers.
module tb_vmon_h2m_decoder;
    import vmon_h2m_pkg::*;

    localparam int MAX_LEN = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  h2m_data;
    logic        h2m_valid;
    logic        h2m_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg_state;

    vmon_h2m_decoder #(.MAX_LEN(MAX_LEN), .SOF(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .h2m_data(h2m_data), .h2m_valid(h2m_valid), .h2m_ready(h2m_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .err_pulse(err_pulse), .err_code(err_code),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // exp_q entry = {op, len, data}
    logic [75:0] exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          exp_frame_cnt = 0;
    int          exp_err_cnt   = 0;
    logic [1:0]  exp_err_code  = 2'd0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  64'(dbg_state), 64'(ST_IDLE));
        check({tag, "_ready"},  64'(h2m_ready), 64'd1);
        check({tag, "_cvalid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_op"},     64'(cmd_op),    64'd0);
        check({tag, "_len"},    64'(cmd_len),   64'd0);
        check({tag, "_data"},   cmd_data,       64'd0);
        check({tag, "_epulse"}, 64'(err_pulse), 64'd0);
        check({tag, "_ecode"},  64'(err_code),  64'd0);
        check({tag, "_fcnt"},   64'(frame_cnt), 64'd0);
        check({tag, "_ecnt"},   64'(err_cnt),   64'd0);
    endtask

    // Asserts reset at a falling edge, checks the asynchronous clear, releases.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_frame_cnt = 0;
        exp_err_cnt   = 0;
        exp_err_code  = 2'd0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge after the transfer.
    // Occasionally idles first with valid low and garbage on the data lines.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if ($urandom_range(0, 3) == 0) begin
            h2m_valid = 1'b0;
            h2m_data  = 8'($urandom);
            @(negedge clk);
        end
        h2m_data  = b;
        h2m_valid = 1'b1;
        while (!h2m_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!h2m_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            h2m_valid = 1'b0;
            return;
        end
        @(negedge clk);
        h2m_valid = 1'b0;
        h2m_data  = 8'($urandom);
    endtask

    // Sends junk, then one frame. chk_flip != 0 corrupts the checksum.
    // Overflowing frames stop after the LEN byte. hold = cycles cmd_ready
    // stays low before the command is taken.
    task automatic run_frame(input logic [7:0] op, input logic [7:0] len,
                             input logic [63:0] pw, input logic [7:0] chk_flip,
                             input int junk, input int hold);
        logic [7:0]  bq[$];
        logic [7:0]  chk;
        logic [7:0]  jb;
        logic [63:0] exp_data;
        logic [75:0] e;
        bit          overflow;
        int          t;

        overflow = (int'(len) > MAX_LEN);
        for (int i = 0; i < junk; i++) begin
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h00;
            bq.push_back(jb);
        end
        bq.push_back(8'hA5);
        bq.push_back(op);
        bq.push_back(len);
        exp_data = 64'd0;
        chk      = op ^ len;
        if (!overflow) begin
            for (int i = 0; i < int'(len); i++) begin
                bq.push_back(pw[8*i +: 8]);
                chk = chk ^ pw[8*i +: 8];
                exp_data = exp_data | (64'(pw[8*i +: 8]) << (8*i));
            end
            bq.push_back(chk ^ chk_flip);
        end

        for (int i = 0; i < bq.size() - 1; i++) begin
            send_byte(bq[i]);
            check("mid_cvalid", 64'(cmd_valid), 64'd0);
            check("mid_epulse", 64'(err_pulse), 64'd0);
        end
        send_byte(bq[bq.size() - 1]);

        if (overflow || chk_flip != 8'd0) begin
            exp_err_code = overflow ? 2'd1 : 2'd2;
            if (exp_err_cnt < 255) exp_err_cnt++;
            check("err_pulse", 64'(err_pulse), 64'd1);
            check("err_code",  64'(err_code),  64'(exp_err_code));
            check("err_cnt",   64'(err_cnt),   64'(exp_err_cnt));
            check("err_nocmd", 64'(cmd_valid), 64'd0);
            check("err_fcnt",  64'(frame_cnt), 64'(exp_frame_cnt));
            @(negedge clk);
            check("err_pulse_end", 64'(err_pulse), 64'd0);
            return;
        end

        exp_q.push_back({op, len[3:0], exp_data});
        // First falling edge after the CHK transfer: command must be up.
        check("cmd_valid", 64'(cmd_valid), 64'd1);
        check("ok_ecode",  64'(err_code),  64'(exp_err_code));
        e = exp_q.pop_front();
        t = 0;
        while (t <= hold) begin
            check("cmd_op",   64'(cmd_op),    64'(e[75:68]));
            check("cmd_len",  64'(cmd_len),   64'(e[67:64]));
            check("cmd_data", cmd_data,       e[63:0]);
            check("out_ready", 64'(h2m_ready), 64'd0);
            if (t < hold) @(negedge clk);
            t++;
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        exp_frame_cnt = (exp_frame_cnt + 1) % 256;
        check("taken_cvalid", 64'(cmd_valid), 64'd0);
        check("taken_ready",  64'(h2m_ready), 64'd1);
        check("frame_cnt",    64'(frame_cnt), 64'(exp_frame_cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        logic [7:0] len;
        rst_n     = 1'b0;
        h2m_valid = 1'b0;
        h2m_data  = 8'h00;
        cmd_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // op 10, two bytes 11 22; valid checksum is 10^02^11^22 = 21
        run_frame(8'h10, 8'd2, 64'h2211, 8'h00, 0, 0);
        // length 9 exceeds the limit, then a good frame still decodes
        run_frame(8'h05, 8'd9, 64'h0, 8'h00, 0, 0);
        run_frame(8'h3C, 8'd8, 64'h8877665544332211, 8'h00, 0, 1);
        check("ecode_held", 64'(err_code), 64'd1);
        // A5,10,01,33,00: correct checksum would be 22, so 00 = flip 22
        do_reset();
        run_frame(8'h10, 8'd1, 64'h33, 8'h22, 0, 0);
        // junk 00,FF is discarded, zero-length frame decodes
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_idle", 64'(dbg_state), 64'(ST_IDLE));
        run_frame(8'h07, 8'd0, 64'h0, 8'h00, 0, 0);
        // consumer stalls 5 cycles, then a back-to-back frame
        run_frame(8'h21, 8'd3, 64'hA5A5A5, 8'h00, 0, 5);
        run_frame(8'h22, 8'd1, 64'h5A, 8'h00, 0, 0);
        // reset after the LEN byte drops the frame silently
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        do_reset();
        run_frame(8'h10, 8'd2, 64'h2211, 8'h00, 0, 0);

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind == 8) len = 8'($urandom_range(MAX_LEN + 1, 255));
            else           len = 8'($urandom_range(0, MAX_LEN));
            run_frame(8'($urandom), len, {$urandom, $urandom},
                      (kind == 9) ? 8'($urandom_range(1, 255)) : 8'h00,
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        check("final_fcnt", 64'(frame_cnt), 64'(exp_frame_cnt));
        check("final_ecnt", 64'(err_cnt),   64'(exp_err_cnt));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
